// File: rtl/uart_pkg.sv
// Shared definitions for the uart host: register map, STATUS bit positions
// and the TX launch FSM encoding.
package uart_pkg;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_BAUD   = 2'd2;
  localparam logic [1:0] UART_REG_IRQ_EN = 2'd3;

  localparam int STAT_RX_VALID   = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_TX_IDLE    = 2;
  localparam int STAT_RX_OVERRUN = 3;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_GUARD = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with one-extra-bit pointers so full and empty are distinct.
// A push on a full FIFO is accepted only when a pop frees a slot on the same edge.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: reads are gated by empty_o.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_host.sv
// Bus-side controller for the 8N1 uart core: TX/RX FIFOs, BAUD register, status.
// Optional interrupt enable register and irq_o are built when UART_HOST_IRQ_EN is defined.
module uart_host
  import uart_pkg::*;
#(
  parameter int          TX_DEPTH   = 16,
  parameter int          RX_DEPTH   = 16,
  parameter logic [15:0] BAUD_RESET = 16'd103
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_start_o,
  input  logic        uart_tx_busy_i,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_ready_i,
  output logic [15:0] uart_compare_o,
  output logic        irq_o
);

  logic [7:0]  tx_head, rx_head;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_start, rx_pop, tx_idle;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] baud_q, baud_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] status;
  logic        unused_wdata;

  assign unused_wdata = ^wdata_i[31:16];

  assign tx_push = we_i && (addr_i == UART_REG_DATA);
  assign rx_pop  = re_i && (addr_i == UART_REG_DATA) && !rx_empty;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (tx_push),
    .pop_i   (tx_start),
    .wdata_i (wdata_i[7:0]),
    .head_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (uart_rx_ready_i),
    .pop_i   (rx_pop),
    .wdata_i (uart_rx_data_i),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // GUARD covers the cycle before the uart reflects the start on busy.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_start   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !uart_tx_busy_i) begin
          tx_start   = 1'b1;
          tx_state_d = TX_GUARD;
        end
      end
      TX_GUARD: tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  assign uart_tx_start_o = tx_start;
  assign uart_tx_data_o  = tx_start ? tx_head : 8'h00;
  assign tx_idle         = tx_empty && (tx_state_q == TX_IDLE) && !uart_tx_busy_i;

  always_comb begin
    status                  = '0;
    status[STAT_RX_VALID]   = !rx_empty;
    status[STAT_TX_FULL]    = tx_full;
    status[STAT_TX_IDLE]    = tx_idle;
    status[STAT_RX_OVERRUN] = rx_overrun_q;
  end

  // A fresh overrun wins over a software clear on the same edge.
  always_comb begin
    baud_d       = baud_q;
    rx_overrun_d = rx_overrun_q;
    if (we_i && (addr_i == UART_REG_BAUD)) baud_d = wdata_i[15:0];
    if (we_i && (addr_i == UART_REG_STATUS) && wdata_i[STAT_RX_OVERRUN]) rx_overrun_d = 1'b0;
    if (uart_rx_ready_i && rx_full && !rx_pop) rx_overrun_d = 1'b1;
  end

`ifdef UART_HOST_IRQ_EN
  logic [1:0] irq_en_q, irq_en_d;
  logic       irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (we_i && (addr_i == UART_REG_IRQ_EN)) irq_en_d = wdata_i[1:0];
    irq_d = (!rx_empty && irq_en_q[0]) || (tx_idle && irq_en_q[1]) ||
            (rx_overrun_q && irq_en_q[0]);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_en_q <= 2'b00;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      case (addr_i)
        UART_REG_DATA:   rdata_d = {24'h0, rx_empty ? 8'h00 : rx_head};
        UART_REG_STATUS: rdata_d = status;
        UART_REG_BAUD:   rdata_d = {16'h0, baud_q};
        default: begin
`ifdef UART_HOST_IRQ_EN
          rdata_d = {30'h0, irq_en_q};
`else
          rdata_d = 32'h0;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state_q   <= TX_IDLE;
      baud_q       <= BAUD_RESET;
      rx_overrun_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      tx_state_q   <= tx_state_d;
      baud_q       <= baud_d;
      rx_overrun_q <= rx_overrun_d;
      rdata_q      <= rdata_d;
    end
  end

  assign rdata_o        = rdata_q;
  assign uart_compare_o = baud_q;

endmodule

// File: tb/tb_uart_host.sv
// Bench for uart_host: directed corner cases plus randomized traffic checked
// against queue-based models of both FIFOs and a behavioural uart transmitter.
module tb_uart_host;
  import uart_pkg::*;

  localparam int TX_DEPTH = 16;
  localparam int RX_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        we, re;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [15:0] compare;
  logic        irq;

  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;
  assign tx_busy = model_busy | hold_busy;

  uart_host dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .we_i            (we),
    .re_i            (re),
    .rdata_o         (rdata),
    .uart_tx_data_o  (tx_data),
    .uart_tx_start_o (tx_start),
    .uart_tx_busy_i  (tx_busy),
    .uart_rx_data_i  (rx_data),
    .uart_rx_ready_i (rx_ready),
    .uart_compare_o  (compare),
    .irq_o           (irq)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];        // bytes accepted by the TX FIFO, in launch order
  logic [7:0] rx_model[$];     // RX FIFO contents
  logic       model_overrun = 1'b0;
  int         start_count = 0;
  int         start_cyc_q[$];
  int         last_start_cyc = -100;
  int         last_fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_status(input logic idle);
    exp_status = {28'h0, model_overrun, idle, (exp_q.size() == TX_DEPTH), (rx_model.size() != 0)};
  endfunction

  // ---------------- uart transmitter model ----------------
  // Busy rises the edge after start and lasts 10 bit times of (compare+1) cycles.
  initial begin : uart_model
    int len;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        check("start_while_busy", {31'h0, tx_busy}, 32'h0);
        start_count++;
        start_cyc_q.push_back(cyc);
        last_start_cyc = cyc;
        if (exp_q.size() == 0) check("tx_unexpected", 32'h1, 32'h0);
        else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        len = 10 * (int'(compare) + 1);
        @(posedge clk); #1 model_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 model_busy = 1'b0;
        last_fall_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic host_send(input logic [7:0] b);
    if (exp_q.size() < TX_DEPTH) exp_q.push_back(b);
    bus_write(UART_REG_DATA, {24'h0, b});
  endtask

  task automatic model_rx_push(input logic [7:0] b);
    if (rx_model.size() < RX_DEPTH) rx_model.push_back(b);
    else model_overrun = 1'b1;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data = b; rx_ready = 1'b1;
    model_rx_push(b);
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic read_data_check(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = (rx_model.size() != 0) ? {24'h0, rx_model.pop_front()} : 32'h0;
    bus_read(UART_REG_DATA, d);
    check(tag, d, e);
  endtask

  task automatic read_with_pulse(input logic [7:0] b);
    logic [31:0] e;
    e = (rx_model.size() != 0) ? {24'h0, rx_model.pop_front()} : 32'h0;
    model_rx_push(b);
    addr = UART_REG_DATA; re = 1'b1; rx_data = b; rx_ready = 1'b1;
    @(negedge clk);
    re = 1'b0; rx_ready = 1'b0;
    check("rd_with_pulse", rdata, e);
  endtask

  task automatic both_access(input logic [7:0] b);
    logic [31:0] e;
    e = (rx_model.size() != 0) ? {24'h0, rx_model.pop_front()} : 32'h0;
    if (exp_q.size() < TX_DEPTH) exp_q.push_back(b);
    addr = UART_REG_DATA; wdata = {24'h0, b}; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    check("both_rd", rdata, e);
  endtask

  task automatic status_check(input string tag, input logic idle);
    logic [31:0] d;
    logic [31:0] e;
    e = exp_status(idle);
    bus_read(UART_REG_STATUS, d);
    check(tag, d, e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy || (cyc - last_start_cyc) < 3) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("tx_drain_timeout", {31'h0, n >= 5000}, 32'h0);
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (start_count < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("start_timeout", {31'h0, n >= 2000}, 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] d;
    int base, wcyc;

    rst_n = 1'b0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    rx_data = '0; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_start", {31'h0, tx_start}, 32'h0);
    check("rst_txdata", {24'h0, tx_data}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_compare", {16'h0, compare}, 32'd103);
    rst_n = 1'b1;
    @(negedge clk);
    status_check("rst_status", 1'b1);

    bus_write(UART_REG_BAUD, 32'h0000_0003);
    bus_read(UART_REG_BAUD, d);
    check("baud_rd", d, 32'd3);
    check("baud_out", {16'h0, compare}, 32'd3);

    // Two bytes: first launches one cycle after the write, second as busy falls.
    base = start_count;
    wcyc = cyc;
    host_send(8'h55);
    host_send(8'hA3);
    wait_starts(base + 2);
    if (start_cyc_q.size() >= base + 2) begin
      check("first_launch", start_cyc_q[base] - wcyc, 32'd1);
      check("launch_gap", {31'h0, (start_cyc_q[base+1] - last_fall_cyc) <= 2}, 32'h1);
    end
    wait_drain();
    status_check("idle_after_two", 1'b1);

    // Seventeen bytes with the uart held busy: the last is dropped.
    hold_busy = 1'b1;
    base = start_count;
    for (int i = 0; i < 17; i++) host_send(8'($urandom_range(0, 255)));
    status_check("tx_full_status", 1'b0);
    @(posedge clk); #1 hold_busy = 1'b0;
    @(negedge clk);
    wait_drain();
    check("tx_sent_16", start_count - base, 32'd16);
    status_check("idle_after_16", 1'b1);

    // Seventeen RX bytes without reading: overrun, then drain and clear.
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) rx_pulse(8'(i));
    status_check("rx_overrun_status", 1'b0);
    for (int i = 0; i < 17; i++) read_data_check("rx_drain");
    bus_write(UART_REG_STATUS, 32'h0000_0008);
    model_overrun = 1'b0;
    status_check("overrun_cleared", 1'b0);

    // Pop and push together on a full RX FIFO: no overrun.
    for (int i = 0; i < RX_DEPTH; i++) rx_pulse(8'($urandom_range(0, 255)));
    read_with_pulse(8'hEE);
    status_check("full_pop_push", 1'b0);
    for (int i = 0; i < RX_DEPTH; i++) read_data_check("rx_after_full");
    // Push and pop together on an empty FIFO: read returns 0, byte kept.
    read_with_pulse(8'h3C);
    read_data_check("rx_empty_push");
    @(posedge clk); #1 hold_busy = 1'b0;
    @(negedge clk);

    // Reset in the middle of a byte.
    base = start_count;
    host_send(8'h11); host_send(8'h22); host_send(8'h33);
    wait_starts(base + 1);
    repeat (5) @(negedge clk);
    bus_read(UART_REG_BAUD, d);
    rst_n = 1'b0;
    exp_q.delete(); rx_model.delete(); model_overrun = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_start", {31'h0, tx_start}, 32'h0);
    check("mid_rst_txdata", {24'h0, tx_data}, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    check("mid_rst_compare", {16'h0, compare}, 32'd103);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(UART_REG_BAUD, d);
    check("baud_after_rst", d, 32'd103);
    check("busy_survives_rst", {31'h0, tx_busy}, 32'h1);
    bus_write(UART_REG_BAUD, 32'h0000_0003);
    host_send(8'h5A);
    wait_drain();
    check("starts_around_rst", start_count - base, 32'd2);

    // Interrupt register.
`ifdef UART_HOST_IRQ_EN
    bus_write(UART_REG_IRQ_EN, 32'h0000_0001);
    bus_read(UART_REG_IRQ_EN, d);
    check("irq_en_rd", d, 32'h1);
    rx_pulse(8'h42);
    check("irq_low_p1", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_high_p2", {31'h0, irq}, 32'h1);
    read_data_check("irq_byte");
    @(negedge clk);
    check("irq_fall", {31'h0, irq}, 32'h0);
    bus_write(UART_REG_IRQ_EN, 32'h0000_0000);
`else
    bus_write(UART_REG_IRQ_EN, 32'h0000_0003);
    bus_read(UART_REG_IRQ_EN, d);
    check("irq_en_rd", d, 32'h0);
    rx_pulse(8'h42);
    @(negedge clk);
    check("irq_tied", {31'h0, irq}, 32'h0);
    read_data_check("irq_byte");
`endif

    // Randomized mixed traffic.
    for (int it = 0; it < 15; it++) begin
      int nw, np, nr;
      nw = $urandom_range(0, 5);
      np = $urandom_range(0, 20);
      nr = $urandom_range(0, 20);
      for (int k = 0; k < nw; k++) host_send(8'($urandom_range(0, 255)));
      for (int k = 0; k < np; k++) rx_pulse(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) both_access(8'($urandom_range(0, 255)));
      for (int k = 0; k < nr; k++) read_data_check("rand_rd");
      wait_drain();
      status_check("rand_status", 1'b1);
      if (model_overrun && $urandom_range(0, 1) == 1) begin
        bus_write(UART_REG_STATUS, 32'h0000_0008);
        model_overrun = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
